// File: rtl/block_check_pkg.sv
// Shared types and constants for the BlockChecker sequencer and its character FIFO.
package block_check_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        FLUSH  = 3'd3,
        WAIT   = 3'd4,
        REPORT = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam int         CNT_W       = 16;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO of {last, char} entries; also counts buffered entries whose last bit is set.
module char_fifo
    import block_check_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  entry_t                  wdata,
    input  logic                    pop,
    output entry_t                  rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  last_cnt
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;
    logic          push_last;
    logic          pop_last;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign rdata     = mem[rd_ptr];
    assign push_last = do_push && wdata.last;
    assign pop_last  = do_pop && rdata.last;

    // NOTE: storage has no reset; the reset pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({push_last, pop_last})
                2'b10:   last_cnt <= last_cnt + 1'b1;
                2'b01:   last_cnt <= last_cnt - 1'b1;
                default: last_cnt <= last_cnt;
            endcase
        end
    end

endmodule

// File: rtl/block_check_sequencer.sv
// Buffers character messages, clears the shared BlockChecker, streams each message into it
// gap-free with a terminating space, and reports a pass/fail verdict plus running counters.
module block_check_sequencer
    import block_check_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CHK_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       chk_in,
    output logic             chk_reset,
    input  logic             chk_result,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic [CNT_W-1:0] msg_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int LW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

    state_t                 state;
    state_t                 state_nx;
    entry_t                 in_entry;
    entry_t                 head;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] lasts_pending;
    logic                   pop;
    logic                   cur_last;
    logic                   overlong;
    logic                   verdict;
    logic [LW-1:0]          wait_cnt;

    assign in_entry = '{last: s_last, data: s_data};
    assign s_ready  = !full;
    assign verdict  = chk_result && !overlong;

    char_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (s_valid),
        .wdata    (in_entry),
        .pop      (pop),
        .rdata    (head),
        .full     (full),
        .empty    (empty),
        .last_cnt (lasts_pending)
    );

    // Popping on the edge that enters each FEED cycle lets chk_in stay registered yet line up with FEED.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise latches are inferred.
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (lasts_pending != '0 || full) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                pop      = !empty;
                state_nx = FEED;
            end
            FEED: begin
                if (cur_last || empty) begin
                    state_nx = FLUSH;
                end else begin
                    pop = 1'b1;
                end
            end
            FLUSH:   state_nx = WAIT;
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nx = REPORT;
                end
            end
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            chk_in    <= ASCII_SPACE;
            chk_reset <= 1'b0;
            cur_last  <= 1'b0;
            overlong  <= 1'b0;
            wait_cnt  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err       <= 1'b0;
            msg_cnt   <= '0;
            fail_cnt  <= '0;
        end else begin
            state     <= state_nx;
            chk_reset <= (state_nx == CLEAR);
            chk_in    <= pop ? head.data : ASCII_SPACE;
            cur_last  <= pop && head.last;
            done      <= (state_nx == REPORT);

            // A full FIFO without any terminator means the message cannot fit.
            if (state == IDLE && state_nx == CLEAR) begin
                overlong <= (lasts_pending == '0);
                if (lasts_pending == '0) begin
                    err <= 1'b1;
                end
            end

            if (state == FLUSH) begin
                wait_cnt <= LW'(CHK_LAT - 1);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if (state_nx == REPORT) begin
                pass    <= verdict;
                msg_cnt <= msg_cnt + 1'b1;
                if (!verdict) begin
                    fail_cnt <= fail_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_block_check_sequencer.sv
// Self-checking bench for block_check_sequencer driving a small begin/end nesting checker model.
module tb_block_check_sequencer;
    import block_check_pkg::*;

    localparam int TB_DEPTH = 16;
    localparam int TB_LAT   = 1;
    localparam int NVEC     = 6;

    logic        clk;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  chk_in;
    logic        chk_reset;
    logic        chk_result;
    logic        done;
    logic        pass;
    logic        err;
    logic [15:0] msg_cnt;
    logic [15:0] fail_cnt;

    typedef struct packed {
        logic [127:0] text;
        logic [4:0]   len;
        logic         exp_pass;
    } vec_t;

    vec_t  vecs [NVEC];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    last_acc = 0;
    int    clr_count = 0;
    int    exp_msg = 0;
    int    exp_fail = 0;
    bit    capturing = 0;
    string cur_stream = "";
    string streams[$];
    logic  passes[$];
    int    done_cyc[$];

    block_check_sequencer #(
        .DEPTH   (TB_DEPTH),
        .CHK_LAT (TB_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .chk_in     (chk_in),
        .chk_reset  (chk_reset),
        .chk_result (chk_result),
        .done       (done),
        .pass       (pass),
        .err        (err),
        .msg_cnt    (msg_cnt),
        .fail_cnt   (fail_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Checker model: words separated by spaces, "begin" opens, "end" closes; balanced and never negative passes.
    initial begin
        logic [39:0] word;
        int          wlen;
        int          depth;
        bit          neg;
        word = '0; wlen = 0; depth = 0; neg = 0;
        chk_result = 1'b1;
        forever begin
            @(negedge clk);
            if (chk_reset) begin
                word = '0; wlen = 0; depth = 0; neg = 0;
            end else if (chk_in == 8'h20) begin
                if (wlen == 5 && word == "begin") begin
                    depth++;
                end else if (wlen == 3 && word[23:0] == "end") begin
                    if (depth == 0) neg = 1;
                    else depth--;
                end
                word = '0;
                wlen = 0;
            end else begin
                word = {word[31:0], chk_in};
                wlen++;
            end
            chk_result = (depth == 0) && !neg;
        end
    end

    // Records the character stream of each message (CLEAR through WAIT) and each verdict.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                capturing = 0;
            end else begin
                if (done) begin
                    streams.push_back(cur_stream);
                    passes.push_back(pass);
                    done_cyc.push_back(cyc);
                    capturing = 0;
                end
                if (chk_reset) begin
                    clr_count++;
                    cur_stream = "";
                    capturing = 1;
                end else if (capturing) begin
                    cur_stream = {cur_stream, $sformatf("%c", chk_in)};
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=\"%s\" expected=\"%s\"", name, act, exp);
        end
    endtask

    function automatic string exp_stream(input logic [127:0] t, input int len);
        string s;
        s = "";
        for (int i = 0; i < len; i++) s = {s, $sformatf("%c", t[8*(len-1-i) +: 8])};
        for (int i = 0; i < 1 + TB_LAT; i++) s = {s, " "};
        return s;
    endfunction

    task automatic push(input logic [7:0] c, input logic last);
        int guard;
        guard = 0;
        @(negedge clk);
        s_data  = c;
        s_last  = last;
        s_valid = 1'b1;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL push: s_ready stuck low for char %0h", c);
        end
        @(posedge clk);
        #1;
        if (last) last_acc = cyc;
    endtask

    task automatic send_text(input logic [127:0] t, input int len, input bit with_last);
        for (int i = 0; i < len; i++) push(t[8*(len-1-i) +: 8], with_last && (i == len - 1));
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_dones(input int n);
        int guard;
        guard = 0;
        while (streams.size() < n && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (streams.size() < n) begin
            total++;
            bad++;
            $display("FAIL done timeout: got=%0d verdicts expected=%0d", streams.size(), n);
        end
        @(negedge clk);
    endtask

    task automatic check_msg(input string name, input int idx, input logic [127:0] t,
                             input int len, input logic exp_pass);
        if (streams.size() > idx) begin
            check_str({name, " stream"}, streams[idx], exp_stream(t, len));
            check({name, " pass"}, 32'(passes[idx]), 32'(exp_pass));
        end
    endtask

    task automatic check_counts(input string name);
        check({name, " msg_cnt"}, 32'(msg_cnt), exp_msg);
        check({name, " fail_cnt"}, 32'(fail_cnt), exp_fail);
    endtask

    task automatic check_latency(input string name, input int idx, input int len);
        if (done_cyc.size() > idx) check({name, " latency"}, done_cyc[idx] - last_acc, len + 3 + TB_LAT);
    endtask

    task automatic check_reset_values(input string name);
        check({name, " s_ready"}, 32'(s_ready), 1);
        check({name, " chk_in"}, 32'(chk_in), 32'h20);
        check({name, " chk_reset"}, 32'(chk_reset), 0);
        check({name, " done"}, 32'(done), 0);
        check({name, " pass"}, 32'(pass), 0);
        check({name, " err"}, 32'(err), 0);
        check({name, " msg_cnt"}, 32'(msg_cnt), 0);
        check({name, " fail_cnt"}, 32'(fail_cnt), 0);
    endtask

    initial begin
        int    base;
        int    base_clr;
        int    guard;
        string name;

        vecs[0] = '{text: 128'("begin end"),        len: 5'd9,  exp_pass: 1'b1};
        vecs[1] = '{text: 128'("begin"),            len: 5'd5,  exp_pass: 1'b0};
        vecs[2] = '{text: 128'("end begin"),        len: 5'd9,  exp_pass: 1'b0};
        vecs[3] = '{text: 128'("x"),                len: 5'd1,  exp_pass: 1'b1};
        vecs[4] = '{text: 128'("begin x end ab c"), len: 5'd16, exp_pass: 1'b1};
        vecs[5] = '{text: 128'("begin begin end"),  len: 5'd15, exp_pass: 1'b0};

        reset   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < NVEC; v++) begin
            base     = streams.size();
            base_clr = clr_count;
            name     = $sformatf("vec%0d", v);
            send_text(vecs[v].text, int'(vecs[v].len), 1'b1);
            idle();
            wait_dones(base + 1);
            exp_msg++;
            if (!vecs[v].exp_pass) exp_fail++;
            check_msg(name, base, vecs[v].text, int'(vecs[v].len), vecs[v].exp_pass);
            check_latency(name, base, int'(vecs[v].len));
            check_counts(name);
            check({name, " chk_reset pulses"}, clr_count - base_clr, 1);
            check({name, " dut pass"}, 32'(pass), 32'(vecs[v].exp_pass));
        end

        // Two messages with no idle cycle between them.
        base     = streams.size();
        base_clr = clr_count;
        send_text(128'("begin end"), 9, 1'b1);
        send_text(128'("end"), 3, 1'b1);
        idle();
        wait_dones(base + 2);
        exp_msg  += 2;
        exp_fail += 1;
        check_msg("b2b first", base, 128'("begin end"), 9, 1'b1);
        check_msg("b2b second", base + 1, 128'("end"), 3, 1'b0);
        check("b2b chk_reset pulses", clr_count - base_clr, 2);
        check_counts("b2b");

        // A message that fills the FIFO without a terminator, followed by its remainder.
        base = streams.size();
        send_text(128'("abcdefghijklmnop"), 16, 1'b0);
        check("overlong s_ready at full", 32'(s_ready), 0);
        check("overlong err before", 32'(err), 0);
        idle();
        wait_dones(base + 1);
        exp_msg++;
        exp_fail++;
        check_msg("overlong", base, 128'("abcdefghijklmnop"), 16, 1'b0);
        check("overlong err", 32'(err), 1);
        check_counts("overlong");
        base = streams.size();
        send_text(128'("zz"), 2, 1'b1);
        idle();
        wait_dones(base + 1);
        exp_msg++;
        check_msg("remainder", base, 128'("zz"), 2, 1'b1);
        check("remainder err sticky", 32'(err), 1);
        check_counts("remainder");

        // Reset in the middle of feeding a message.
        send_text(128'("begin end"), 9, 1'b1);
        idle();
        guard = 0;
        while (!chk_reset && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("midreset saw clear", 32'(chk_reset), 1);
        repeat (3) @(negedge clk);
        check("midreset feeding", 32'(chk_in), 32'h67);
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        reset    = 1'b1;
        base     = streams.size();
        base_clr = clr_count;
        repeat (30) @(negedge clk);
        check("midreset no verdict", streams.size() - base, 0);
        check("midreset fifo discarded", clr_count - base_clr, 0);
        exp_msg  = 0;
        exp_fail = 0;
        send_text(128'("begin end"), 9, 1'b1);
        idle();
        wait_dones(base + 1);
        exp_msg++;
        check_msg("after reset", base, 128'("begin end"), 9, 1'b1);
        check_latency("after reset", base, 9);
        check_counts("after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_check_sequencer.md
# block_check_sequencer

Controller that sequences the shared BlockChecker keyword/nesting checker. It buffers incoming character messages from an upstream source and clears the checker before each message. It then streams each message into the checker one character per cycle with no gaps, appends a terminating space, and reports a per-message pass/fail verdict with running counters.

## Interface
- `DEPTH`, 8: character FIFO entries (power of two, ≥ 4); maximum message length.
- `CHK_LAT`, 1: cycles from the last checker input to a valid `chk_result`.
- `clk`  input  1  clock; all state updates on rising edge.
- `reset`  input  1  one clock; reset is asynchronous and active-low.
- `s_data`  input  8  ASCII character from the upstream source.
- `s_last`  input  1  marks the final character of a message.
- `s_valid`  input  1  upstream character valid.
- `s_ready`  output  1  FIFO can accept; a transfer happens when `s_valid && s_ready`.
- `chk_in`  output  8  character driven to the checker; the checker consumes one character every cycle.
- `chk_reset`  output  1  active-high synchronous clear to the checker.
- `chk_result`  input  1  checker verdict (1 = all blocks balanced).
- `done`  output  1  one-cycle pulse when a verdict is available.
- `pass`  output  1  verdict; valid while `done` = 1, otherwise holds its last value.
- `err`  output  1  sticky: a message exceeded `DEPTH`; cleared only by reset.
- `msg_cnt`  output  16  number of messages reported; wraps.
- `fail_cnt`  output  16  number of failed messages; wraps.

## Operation
- The FIFO stores `{s_last, s_data}`, giving 9 bits per entry. `lasts_pending` counts the buffered entries that have `s_last` = 1.
- **IDLE**
  - `chk_in` = 8'h20 (space); `chk_reset` = 0.
  - Go to CLEAR when `lasts_pending` > 0.
  - Also go to CLEAR when the FIFO is full and `lasts_pending` = 0. In that case set `err` and flag the current message as overlong.
- **CLEAR**: assert `chk_reset` = 1 for exactly one cycle; `chk_in` = space. Then go to FEED.
- **FEED**: each cycle, pop one entry and drive its character on `chk_in`.
  - On popping a `last` entry, go to FLUSH.
  - For an overlong message, FEED stops when the FIFO is empty, then goes to FLUSH. Any remaining characters of that message are treated as a new message.
- **FLUSH**: drive space for one cycle so that a trailing keyword is terminated. Then go to WAIT.
- **WAIT**: hold `chk_in` = space for `CHK_LAT` cycles, then go to REPORT.
- **REPORT**
  - Sample `chk_result`, pulse `done`, and set `pass` = `chk_result && !overlong`.
  - Increment `msg_cnt`; increment `fail_cnt` if `!pass`.
  - Return to IDLE.
- **FIFO rules**
  - The FIFO accepts pushes in every state; pops happen only in FEED.
  - On a simultaneous push and pop, occupancy is unchanged. `lasts_pending` is updated by push-last minus pop-last in the same cycle.
  - `s_ready` = !full. When full, a push and a pop in the same cycle is still refused: `s_ready` is registered-free and depends only on `full`.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally. Occupancy is a `$clog2(DEPTH)+1`-bit counter.
- Counters wrap from 16'hFFFF to 0.

## Timing
- Reset (`reset` = 0) values:
  - state = IDLE; FIFO empty.
  - `s_ready` = 1, `chk_in` = 8'h20, `chk_reset` = 0.
  - `done` = 0, `pass` = 0, `err` = 0, `msg_cnt` = 0, `fail_cnt` = 0.
- All outputs are registered except `s_ready`.
- Latency for an N-character message, counted from the cycle in which its `last` is accepted:
  - 1 cycle to detect it in IDLE, 1 cycle in CLEAR, N cycles in FEED, 1 in FLUSH, `CHK_LAT` in WAIT.
  - `done` asserts on the cycle after that (REPORT).
  - Total: N + 3 + `CHK_LAT` cycles.
- Characters reach the checker on consecutive cycles with no bubbles inside a message.
- Back-to-back messages are separated by at least 3 + `CHK_LAT` non-message cycles, including CLEAR.
- Reset asserted mid-message aborts the message: no `done` is issued, and the FIFO contents are discarded.

## Structure
- Shared package `block_check_pkg`:
  - state enum {IDLE, CLEAR, FEED, FLUSH, WAIT, REPORT}
  - `ASCII_SPACE` = 8'h20
  - counter width constant 16
- One sub-module, `char_fifo`: a parameterised synchronous FIFO with push, pop, full, empty, and a `last` count output.
- The FSM, WAIT counter, and statistics counters live in `block_check_sequencer`.

## Test plan
- Message "begin end" with the checker model returning 1 → `chk_reset` pulse, then 9 characters followed by a space on `chk_in`; `done` pulses with `pass` = 1 at cycle N+4 = 13 after `last`; `msg_cnt` = 1.
- Message "begin" with the model returning 0 → `pass` = 0, `fail_cnt` = 1.
- Two messages pushed back-to-back with no idle cycles → both reported in order; `chk_reset` pulses twice; no gaps appear inside either message.
- 10 characters with no `last` and `DEPTH` = 8 → `s_ready` drops at 8 entries; `err` = 1; first verdict has `pass` = 0; the remainder is reported as a separate message.
- Reset driven low during FEED → all outputs return to their reset values immediately; no `done` is issued; the next message is processed normally.
- `msg_cnt` preset near wrap by running 65537 short messages (or forced) → count wraps to 1.
